// File: rtl/demux_1_to_3_buffered.sv
// rtl/demux_1_to_3_buffered.sv - steer one source onto three held, handshaked destination buffers
// Each destination slot is a one-entry EMPTY/FULL buffer with a saturating delivery counter.

module demux_1_to_3_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [WIDTH-1:0] wdata,
    input  logic             take,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             space,
    output logic [CNT_W-1:0] cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            data  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                        data  <= wdata;
                    end
                end
                FULL: begin
                    // A refill in the same cycle as a consume keeps the slot full (no bubble).
                    if (accept) begin
                        data <= wdata;
                    end else if (take) begin
                        state <= EMPTY;
                    end
                    if (take && (cnt != '1)) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign valid = (state == FULL);
    assign space = (state == EMPTY) | take;
endmodule

module demux_1_to_3_buffered #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [1:0]       in_dest,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_first,
    output logic [WIDTH-1:0] out_second,
    output logic [WIDTH-1:0] out_third,
    output logic             valid_first,
    output logic             valid_second,
    output logic             valid_third,
    input  logic             ready_first,
    input  logic             ready_second,
    input  logic             ready_third,
    output logic             err_dest,
    output logic [CNT_W-1:0] cnt_first,
    output logic [CNT_W-1:0] cnt_second,
    output logic [CNT_W-1:0] cnt_third
);
    logic space_first;
    logic space_second;
    logic space_third;
    logic accepted;

    always_comb begin
        in_ready = 1'b1;
        case (in_dest)
            2'd0:    in_ready = space_first;
            2'd1:    in_ready = space_second;
            2'd2:    in_ready = space_third;
            default: in_ready = 1'b1;
        endcase
    end

    assign accepted = in_valid & in_ready;

    demux_1_to_3_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_first (
        .clk    (clk),
        .rst    (rst),
        .accept (accepted & (in_dest == 2'd0)),
        .wdata  (in_data),
        .take   (ready_first),
        .data   (out_first),
        .valid  (valid_first),
        .space  (space_first),
        .cnt    (cnt_first)
    );

    demux_1_to_3_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_second (
        .clk    (clk),
        .rst    (rst),
        .accept (accepted & (in_dest == 2'd1)),
        .wdata  (in_data),
        .take   (ready_second),
        .data   (out_second),
        .valid  (valid_second),
        .space  (space_second),
        .cnt    (cnt_second)
    );

    demux_1_to_3_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_third (
        .clk    (clk),
        .rst    (rst),
        .accept (accepted & (in_dest == 2'd2)),
        .wdata  (in_data),
        .take   (ready_third),
        .data   (out_third),
        .valid  (valid_third),
        .space  (space_third),
        .cnt    (cnt_third)
    );

    // Illegal destination: word is dropped, only a one-cycle error pulse remains.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_dest <= 1'b0;
        end else begin
            err_dest <= accepted & (in_dest == 2'd3);
        end
    end
endmodule
